// File: rtl/sort4_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sort4_seq_ctrl
// Description : Sorts four W-bit unsigned values into descending order with one
//               shared compare-swap unit stepped through a five-step odd-even
//               schedule. Optional swap counter: define SORT4_SWAP_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sort4_seq_ctrl #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [4*W-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [4*W-1:0] out_data,
    output logic           busy
`ifdef SORT4_SWAP_CNT_EN
    ,
    output logic [2:0]     swap_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] c_LAST_STEP = 3'd4;

    state_t         r_state;
    state_t         w_stateNext;
    logic [2:0]     r_step;
    logic [W-1:0]   r_elem [4];

    logic [1:0]     w_idxX;
    logic [1:0]     w_idxY;
    logic [W-1:0]   w_opX;
    logic [W-1:0]   w_opY;
    logic           w_swap;
    logic           w_lastStep;

    // Compare-swap pair for the current step; x is always the lower index.
    always_comb begin
        w_idxX = 2'd1;
        w_idxY = 2'd2;
        case (r_step)
            3'd0: begin w_idxX = 2'd0; w_idxY = 2'd2; end
            3'd1: begin w_idxX = 2'd1; w_idxY = 2'd3; end
            3'd2: begin w_idxX = 2'd0; w_idxY = 2'd1; end
            3'd3: begin w_idxX = 2'd2; w_idxY = 2'd3; end
            default: begin w_idxX = 2'd1; w_idxY = 2'd2; end
        endcase
    end

    assign w_opX = r_elem[w_idxX];
    assign w_opY = r_elem[w_idxY];

    // The single magnitude comparator: exchange only when y is strictly larger,
    // which is the same decision the swap counter needs.
    assign w_swap     = (w_opY > w_opX);
    assign w_lastStep = (r_step == c_LAST_STEP);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_stateNext = SORT;
                end
            end
            SORT: begin
                busy = 1'b1;
                if (w_lastStep) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_step <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                r_elem[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_elem[0] <= in_data[4*W-1 -: W];
                        r_elem[1] <= in_data[3*W-1 -: W];
                        r_elem[2] <= in_data[2*W-1 -: W];
                        r_elem[3] <= in_data[W-1   -: W];
                        r_step    <= 3'd0;
                    end
                end
                SORT: begin
                    if (w_swap) begin
                        r_elem[w_idxX] <= w_opY;
                        r_elem[w_idxY] <= w_opX;
                    end
                    r_step <= w_lastStep ? 3'd0 : r_step + 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Working registers double as the output holding register.
    assign out_data = {r_elem[0], r_elem[1], r_elem[2], r_elem[3]};

`ifdef SORT4_SWAP_CNT_EN
    logic [2:0] r_swapCnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_swapCnt <= 3'd0;
        end else if (r_state == IDLE && in_valid) begin
            r_swapCnt <= 3'd0;
        end else if (r_state == SORT && w_swap) begin
            r_swapCnt <= r_swapCnt + 3'd1;
        end
    end

    assign swap_cnt = r_swapCnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sort4_seq_ctrl.sv
`default_nettype none
// Testbench for sort4_seq_ctrl: directed vector table, backpressure, mid-sort
// reset, and a randomized regression against a reference sort.
module tb_sort4_seq_ctrl;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           nrst;
    logic           in_valid;
    logic           in_ready;
    logic [4*W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [4*W-1:0] out_data;
    logic           busy;
`ifdef SORT4_SWAP_CNT_EN
    logic [2:0]     swapCnt;
`endif

    int checks = 0;
    int errors = 0;

    sort4_seq_ctrl #(.W(W)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef SORT4_SWAP_CNT_EN
        ,
        .swap_cnt  (swapCnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] din;
        logic [15:0] dout;
        int          swaps;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Descending reference via plain bubble sort.
    function automatic logic [15:0] refSort(input logic [15:0] d);
        logic [3:0] a [4];
        logic [3:0] t;
        for (int i = 0; i < 4; i++) a[i] = d[15-4*i -: 4];
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 3; i++)
                if (a[i] < a[i+1]) begin
                    t = a[i]; a[i] = a[i+1]; a[i+1] = t;
                end
        return {a[0], a[1], a[2], a[3]};
    endfunction

    // Offer a vector and return right after the accept edge.
    task automatic sendVec(input logic [15:0] d);
        int n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) chk("in_ready timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
    endtask

    // Cycles counted from the accept edge until out_valid is seen.
    task automatic waitOut(output int lat, output int busyCnt);
        lat     = 1;
        busyCnt = 0;
        while (!out_valid && lat < 20) begin
            if (busy) busyCnt++;
            step();
            lat++;
        end
    endtask

    task automatic runVec(input logic [15:0] d, input logic [15:0] exp, input int sw);
        int lat;
        int bc;
        out_ready = 1'b1;
        sendVec(d);
        waitOut(lat, bc);
        chk($sformatf("latency %h", d), lat, 32'd6);
        chk($sformatf("busy cycles %h", d), bc, 32'd5);
        chk($sformatf("out_data %h", d), {16'd0, out_data}, {16'd0, exp});
`ifdef SORT4_SWAP_CNT_EN
        chk($sformatf("swap_cnt %h", d), {29'd0, swapCnt}, sw);
`else
        if (sw < 0) $display("bad table entry");
`endif
        step();
        chk($sformatf("out_valid drop %h", d), {31'd0, out_valid}, 32'd0);
        chk($sformatf("in_ready back %h", d), {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        int bc;
        logic [15:0] d;

        vecs[0] = '{16'h1234, 16'h4321, 4};
        vecs[1] = '{16'hF952, 16'hF952, 0};
        vecs[2] = '{16'h7777, 16'h7777, 0};
        vecs[3] = '{16'h3131, 16'h3311, 1};
        vecs[4] = '{16'h0F0F, 16'hFF00, 3};
        vecs[5] = '{16'h2A5C, 16'hCA52, 5};
        vecs[6] = '{16'h8421, 16'h8421, 0};
        vecs[7] = '{16'h0000, 16'h0000, 0};

        nrst      = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b0;
        #12;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset out_data", {16'd0, out_data}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            runVec(vecs[i].din, vecs[i].dout, vecs[i].swaps);
        end

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        sendVec(16'h1234);
        waitOut(lat, bc);
        chk("bp latency", lat, 32'd6);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = 16'hABCD;
            chk($sformatf("bp out_valid c%0d", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp out_data c%0d", c), {16'd0, out_data}, 32'h4321);
            chk($sformatf("bp in_ready c%0d", c), {31'd0, in_ready}, 32'd0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp release out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp no stray sort", {31'd0, busy}, 32'd0);
        step();
        chk("bp still idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of a sort.
        out_ready = 1'b1;
        sendVec(16'h0F0F);
        step();
        step();
        chk("mid busy before reset", {31'd0, busy}, 32'd1);
        #2 nrst = 1'b0;
        #1;
        chk("async in_ready", {31'd0, in_ready}, 32'd1);
        chk("async busy", {31'd0, busy}, 32'd0);
        chk("async out_valid", {31'd0, out_valid}, 32'd0);
        chk("async out_data", {16'd0, out_data}, 32'd0);
        #2 nrst = 1'b1;
        step();
        runVec(16'h8421, 16'h8421, 0);

        // Random regression with idle gaps and random backpressure.
        for (int v = 0; v < 1000; v++) begin
            bit got;
            d = 16'($urandom);
            out_ready = 1'b0;
            repeat ($urandom_range(0, 3)) step();
            sendVec(d);
            got = 1'b0;
            for (int c = 0; c < 60 && !got; c++) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    chk($sformatf("rand %0d in %h", v, d), {16'd0, out_data}, {16'd0, refSort(d)});
                    got = 1'b1;
                end
                step();
            end
            if (!got) chk($sformatf("rand %0d timeout", v), 32'd0, 32'd1);
            chk($sformatf("rand %0d single out", v), {31'd0, out_valid}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
